sine_compare_gen: RTL and testbench
===================================

# sine_compare_gen

Upstream modulation stage for the level PWM cells. Generates a sinusoidal 16-bit compare word from a DDS phase accumulator, a quarter-wave sine ROM and an amplitude (modulation-index) multiplier. It is scaled to the carrier span `0..PWMMaxCount`. The block advances once per carrier-update tick and drives the `Compare` input of every level cell on one phase leg.

## Interface
- `PHASE_WIDTH`, 32: phase accumulator width.
- `LUT_ADDR_W`, 8: quarter-wave ROM address width (2^8 entries).
- `MClk` input 1: system clock; all logic on rising edge.
- `RstN` input 1: reset, synchronous, active-low.
- `Enable` input 1: run; low holds the generator idle and clears phase.
- `UpdateTick` input 1: one-cycle strobe; each high cycle produces one new sample.
- `PhaseStep` input PHASE_WIDTH: frequency tuning word added per tick.
- `Amplitude` input 16: modulation index, unsigned Q0.16 (0xFFFF ≈ 1.0).
- `PWMMaxCount` input 16: carrier peak; same value as fed to the level cells.
- `Compare` output 16: compare word for the level cells.
- `CompareValid` output 1: one-cycle pulse when `Compare` changes.

## Operation
- Ticks are accepted only when `Enable`=1. The phase used for a sample is the accumulator value before the increment; the accumulator then wraps modulo 2^PHASE_WIDTH (`acc <= acc + PhaseStep`).
- Phase fold:
  - `quad = phase[MSB:MSB-1]`.
  - `idx` = the next LUT_ADDR_W bits.
  - In quadrants 1 and 3, `idx` is replaced by `~idx`.
  - Sign is negative in quadrants 2 and 3.
- ROM entry i = round(32767·sin((i+0.5)·π/2^(LUT_ADDR_W+1))), unsigned 15-bit. The half-sample offset makes the mirror exact.
- `scaled = (mag·Amplitude) >> 16`, 15 bits.
- `half = PWMMaxCount >> 1`.
- `d = (scaled·half) >> 15`, truncating.
- `Compare = half + d` when the sign is positive, `half − d` when negative. The result is clamped to the range `[0, PWMMaxCount]`.
- `Enable` falling: the accumulator clears to 0 on the next edge. Ticks are ignored. Samples already in the pipeline complete and emit. `Compare` then holds its last value.
- Changes to `PhaseStep`, `Amplitude` or `PWMMaxCount` take effect at the pipeline stage that consumes them. No shadowing is done here; the level cells latch at their own period boundary.

## Timing
- Fully pipelined, 3-cycle latency. `UpdateTick` sampled at edge N:
  - N: accumulator update and phase capture.
  - N+1: fold and ROM read.
  - N+2: amplitude multiply.
  - N+3: offset, clamp and `Compare` register.
- `CompareValid` is high for the single cycle following edge N+3.
- Back-to-back ticks on every cycle are legal; each tick yields exactly one `CompareValid`.
- Reset (synchronous `RstN`=0 at any edge, including mid-pipeline) clears:
  - `acc`=0
  - all stage valids = 0
  - `Compare`=0
  - `CompareValid`=0
- In-flight samples are discarded. The first tick after reset uses phase 0.
- `UpdateTick` while `Enable`=0 produces no `CompareValid`.

## Configuration
- `PHASE_OFFSET_EN` defined: adds input `PhaseOffset` (PHASE_WIDTH). The ROM phase becomes `acc + PhaseOffset` (mod 2^PHASE_WIDTH), registered in the N stage, so latency is unchanged. This provides 120° legs.
- `PHASE_OFFSET_EN` undefined: the port is absent and the offset is 0.

## Structure
- Shared package `pwm_pkg`:
  - `PHASE_WIDTH` and `LUT_ADDR_W` defaults
  - `compare_t` (logic [15:0])
  - `quadrant_t` enum {Q0,Q1,Q2,Q3}
- Sub-module `sine_quarter_rom`: synchronous-read quarter-wave table, 1-cycle latency, contents generated by the formula above.

## Test plan
- Reset check: `RstN`=0 for 3 cycles mid-run → `Compare`=0 and `CompareValid`=0. The first tick after reset gives `Compare`=250 with `PWMMaxCount`=500, `Amplitude`=0xFFFF and `PhaseStep`=0x0100_0000.
- Waveform values, same setup:
  - tick 64 (phase 0x4000_0000) → `Compare`=499
  - tick 192 → `Compare`=1
  - tick 256 wraps to phase 0 → `Compare`=250
- Latency: single tick → `CompareValid` exactly 3 edges later, one cycle wide. Ticks on 5 consecutive cycles → 5 consecutive valid pulses.
- Amplitude scaling: `Amplitude`=0x8000 at tick 64 → `Compare`=374. `Amplitude`=0 → `Compare`=250 on every tick.
- Enable and clamp:
  - `Enable` dropped mid-stream → in-flight samples still emit, later ticks ignored.
  - Re-enable → phase restarts at 0.
  - `PWMMaxCount`=0 → `Compare`=0.
- `PHASE_OFFSET_EN` with `PhaseOffset`=0x4000_0000, first tick → `Compare`=499.

Source files
------------

// File: rtl/pwm_pkg.sv
// -----------------------------------------------------------------------------
// pwm_pkg
// Shared types and defaults for the PWM modulation path.
//   DEFAULT_PHASE_WIDTH : phase accumulator width default (32)
//   DEFAULT_LUT_ADDR_W  : quarter-wave sine table address width default (8)
//   MAG_W               : width of an unsigned sine magnitude (15)
//   compare_t           : 16-bit compare word fed to the level cells
//   quadrant_t          : phase quadrant Q0..Q3
//   sine_rom_entry()    : elaboration-time generator for the sine table
// -----------------------------------------------------------------------------
package pwm_pkg;

  localparam int DEFAULT_PHASE_WIDTH = 32;
  localparam int DEFAULT_LUT_ADDR_W  = 8;
  localparam int MAG_W               = 15;

  localparam real SINE_PI = 3.14159265358979323846;

  typedef logic [15:0] compare_t;

  typedef enum logic [1:0] {
    Q0 = 2'd0,
    Q1 = 2'd1,
    Q2 = 2'd2,
    Q3 = 2'd3
  } quadrant_t;

  // Table entry i = round(32767 * sin((i + 0.5) * pi / 2^(addr_w+1))).
  // A Taylor series is used instead of $sin so the table only needs basic
  // real arithmetic at elaboration; 10 terms are far below 1 LSB of error
  // over [0, pi/2].
  function automatic logic [MAG_W-1:0] sine_rom_entry(input int idx, input int addr_w);
    real x;
    real term;
    real sum;
    x    = (real'(idx) + 0.5) * SINE_PI / real'(2 ** (addr_w + 1));
    term = x;
    sum  = x;
    for (int k = 1; k < 10; k++) begin
      term = -term * x * x / real'((2 * k) * (2 * k + 1));
      sum  = sum + term;
    end
    return MAG_W'($rtoi(32767.0 * sum + 0.5));
  endfunction

endpackage

// File: rtl/sine_quarter_rom.sv
// -----------------------------------------------------------------------------
// sine_quarter_rom
// Quarter-wave sine magnitude table with a registered (one-cycle) read.
// Entries are sampled at half-step offsets so that reading the table with
// the inverted address yields the exact mirror for the falling quarter.
// Ports:
//   clk     : clock, rising edge
//   rd_addr : table address (ADDR_W bits)
//   rd_data : magnitude, unsigned MAG_W bits, valid one cycle after rd_addr
// -----------------------------------------------------------------------------
module sine_quarter_rom
  import pwm_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_LUT_ADDR_W
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [MAG_W-1:0]  rd_data
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [MAG_W-1:0] rom_table [DEPTH];
  logic [MAG_W-1:0] rd_data_d;
  logic [MAG_W-1:0] rd_data_q;

  // Contents are fixed at elaboration; the localparam forces the constant
  // function to be evaluated by the tools rather than built as logic.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    localparam logic [MAG_W-1:0] ENTRY = sine_rom_entry(gi, ADDR_W);
    assign rom_table[gi] = ENTRY;
  end

  always_comb begin
    rd_data_d = rom_table[rd_addr];
  end

  // No reset on the read register so the table maps onto block RAM.
  always_ff @(posedge clk) begin
    rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/sine_compare_gen.sv
// -----------------------------------------------------------------------------
// sine_compare_gen
// DDS sine modulator producing a compare word in 0..PWMMaxCount for the
// level PWM cells of one phase leg. One sample per accepted UpdateTick,
// fully pipelined with 3 cycles of latency:
//   edge N   : accumulator update, phase capture
//   edge N+1 : quadrant fold, quarter-wave ROM read
//   edge N+2 : amplitude multiply
//   edge N+3 : offset around mid-scale, clamp, Compare register
// CompareValid is high for the cycle following edge N+3.
//
// Ports:
//   MClk         : clock, rising edge
//   RstN         : synchronous active-low reset
//   Enable       : run; low clears the accumulator and ignores ticks
//   UpdateTick   : one-cycle strobe requesting a new sample
//   PhaseStep    : frequency tuning word added per accepted tick
//   PhaseOffset  : static phase offset (present only with PHASE_OFFSET_EN)
//   Amplitude    : modulation index, unsigned Q0.16
//   PWMMaxCount  : carrier peak count
//   Compare      : compare word for the level cells
//   CompareValid : one-cycle pulse when Compare is updated
//
// Build option: define PHASE_OFFSET_EN to add the PhaseOffset port; the
// ROM phase then becomes acc + PhaseOffset. Undefined, the offset is 0.
// -----------------------------------------------------------------------------
module sine_compare_gen
  import pwm_pkg::*;
#(
  parameter int PHASE_WIDTH = DEFAULT_PHASE_WIDTH,
  parameter int LUT_ADDR_W  = DEFAULT_LUT_ADDR_W
) (
  input  logic                   MClk,
  input  logic                   RstN,
  input  logic                   Enable,
  input  logic                   UpdateTick,
  input  logic [PHASE_WIDTH-1:0] PhaseStep,
`ifdef PHASE_OFFSET_EN
  input  logic [PHASE_WIDTH-1:0] PhaseOffset,
`endif
  input  logic [15:0]            Amplitude,
  input  logic [15:0]            PWMMaxCount,
  output logic [15:0]            Compare,
  output logic                   CompareValid
);

  // Only the quadrant bits and the table index of the phase are kept.
  localparam int FOLD_W = LUT_ADDR_W + 2;
  localparam int SHIFT  = PHASE_WIDTH - FOLD_W;

  logic [PHASE_WIDTH-1:0] phase_offset;

`ifdef PHASE_OFFSET_EN
  assign phase_offset = PhaseOffset;
`else
  assign phase_offset = '0;
`endif

  // Stage 0: accumulator and captured phase
  logic [PHASE_WIDTH-1:0] acc_d, acc_q;
  logic [FOLD_W-1:0]      phase_d, phase_q;
  logic                   v0_d, v0_q;

  // Stage 1: fold and ROM read
  quadrant_t              quad;
  logic [LUT_ADDR_W-1:0]  idx;
  logic [LUT_ADDR_W-1:0]  rom_addr;
  logic [MAG_W-1:0]       mag;
  logic                   neg1_d, neg1_q;
  logic                   v1_d, v1_q;

  // Stage 2: amplitude scaling
  logic [MAG_W-1:0]       scaled_d, scaled_q;
  logic                   neg2_d, neg2_q;
  logic                   v2_d, v2_q;

  // Stage 3: offset, clamp, output
  logic [14:0]            half;
  logic [MAG_W-1:0]       delta;
  logic signed [17:0]     level;
  compare_t               compare_d, compare_q;
  logic                   valid_d, valid_q;

  sine_quarter_rom #(
    .ADDR_W (LUT_ADDR_W)
  ) u_rom (
    .clk     (MClk),
    .rd_addr (rom_addr),
    .rd_data (mag)
  );

  // Stage 0. The sample uses the accumulator value before the increment.
  always_comb begin
    acc_d   = acc_q;
    phase_d = phase_q;
    v0_d    = 1'b0;
    if (!Enable) begin
      acc_d = '0;
    end else if (UpdateTick) begin
      acc_d   = acc_q + PhaseStep;
      phase_d = FOLD_W'((acc_q + phase_offset) >> SHIFT);
      v0_d    = 1'b1;
    end
  end

  // Stage 1. Quadrants 1 and 3 run the table backwards; 2 and 3 are negative.
  always_comb begin
    quad     = quadrant_t'(phase_q[FOLD_W-1 -: 2]);
    idx      = phase_q[LUT_ADDR_W-1:0];
    rom_addr = ((quad == Q1) || (quad == Q3)) ? ~idx : idx;
    neg1_d   = (quad == Q2) || (quad == Q3);
    v1_d     = v0_q;
  end

  // Stage 2. mag (15b) * Amplitude (Q0.16) keeps a 15-bit magnitude.
  always_comb begin
    scaled_d = MAG_W'((32'(mag) * 32'(Amplitude)) >> 16);
    neg2_d   = neg1_q;
    v2_d     = v1_q;
  end

  // Stage 3. Swing around mid-scale, truncating toward the centre.
  always_comb begin
    half      = PWMMaxCount[15:1];
    delta     = MAG_W'((32'(scaled_q) * 32'(half)) >> 15);
    level     = neg2_q ? ($signed({3'b000, half}) - $signed({3'b000, delta}))
                       : ($signed({3'b000, half}) + $signed({3'b000, delta}));
    compare_d = compare_q;
    valid_d   = v2_q;
    if (v2_q) begin
      if (level < 18'sd0) begin
        compare_d = '0;
      end else if (level > $signed({2'b00, PWMMaxCount})) begin
        compare_d = PWMMaxCount;
      end else begin
        compare_d = level[15:0];
      end
    end
  end

  always_ff @(posedge MClk) begin
    if (!RstN) begin
      acc_q     <= '0;
      phase_q   <= '0;
      v0_q      <= 1'b0;
      neg1_q    <= 1'b0;
      v1_q      <= 1'b0;
      scaled_q  <= '0;
      neg2_q    <= 1'b0;
      v2_q      <= 1'b0;
      compare_q <= '0;
      valid_q   <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      phase_q   <= phase_d;
      v0_q      <= v0_d;
      neg1_q    <= neg1_d;
      v1_q      <= v1_d;
      scaled_q  <= scaled_d;
      neg2_q    <= neg2_d;
      v2_q      <= v2_d;
      compare_q <= compare_d;
      valid_q   <= valid_d;
    end
  end

  assign Compare      = compare_q;
  assign CompareValid = valid_q;

endmodule

// File: tb/tb_sine_compare_gen.sv
// -----------------------------------------------------------------------------
// tb_sine_compare_gen
// Directed bench for sine_compare_gen with hand-computed compare values
// (PWMMaxCount = 500, PhaseStep = 0x0100_0000 unless noted).
// Define PHASE_OFFSET_EN to also exercise the PhaseOffset port.
// -----------------------------------------------------------------------------
module tb_sine_compare_gen;

  logic        MClk = 1'b0;
  logic        RstN;
  logic        Enable;
  logic        UpdateTick;
  logic [31:0] PhaseStep;
`ifdef PHASE_OFFSET_EN
  logic [31:0] PhaseOffset;
`endif
  logic [15:0] Amplitude;
  logic [15:0] PWMMaxCount;
  logic [15:0] Compare;
  logic        CompareValid;

  int checks_total  = 0;
  int checks_passed = 0;

  always #5 MClk = ~MClk;

  sine_compare_gen dut (
    .MClk         (MClk),
    .RstN         (RstN),
    .Enable       (Enable),
    .UpdateTick   (UpdateTick),
    .PhaseStep    (PhaseStep),
`ifdef PHASE_OFFSET_EN
    .PhaseOffset  (PhaseOffset),
`endif
    .Amplitude    (Amplitude),
    .PWMMaxCount  (PWMMaxCount),
    .Compare      (Compare),
    .CompareValid (CompareValid)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks_total++;
    if (observed === expected) begin
      checks_passed++;
      $display("check %-28s observed=%0d expected=%0d ok", tag, observed, expected);
    end else begin
      $display("FAIL %-28s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Advance one clock; outputs are read 1 time unit after the edge.
  task automatic step();
    @(posedge MClk);
    #1;
  endtask

  // Clear the accumulator via Enable so the next tick uses phase 0.
  task automatic restart();
    Enable = 1'b0;
    step();
    Enable = 1'b1;
  endtask

  // Issue n back-to-back ticks without checking, then let the pipe drain.
  task automatic skip_ticks(input int n);
    UpdateTick = 1'b1;
    repeat (n) step();
    UpdateTick = 1'b0;
    repeat (4) step();
  endtask

  // One tick: check latency, value and single-cycle valid width.
  task automatic do_tick(input string tag, input logic [15:0] exp_cmp);
    int lat;
    lat = 0;
    UpdateTick = 1'b1;
    step();
    UpdateTick = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      step();
      if (CompareValid === 1'b1) begin
        lat = k;
        break;
      end
    end
    check({tag, " latency"}, lat, 3);
    check({tag, " compare"}, Compare, exp_cmp);
    step();
    check({tag, " valid width"}, CompareValid, 0);
  endtask

  initial begin
    int cnt;
    int first_e;
    int last_e;

    RstN        = 1'b0;
    Enable      = 1'b1;
    UpdateTick  = 1'b0;
    PhaseStep   = 32'h0100_0000;
    Amplitude   = 16'hFFFF;
    PWMMaxCount = 16'd500;
`ifdef PHASE_OFFSET_EN
    PhaseOffset = 32'h0;
`endif

    repeat (3) step();
    check("reset compare", Compare, 0);
    check("reset valid", CompareValid, 0);
    RstN = 1'b1;

    // Advance the phase, then reset with a sample in flight.
    skip_ticks(10);
    UpdateTick = 1'b1;
    step();
    UpdateTick = 1'b0;
    RstN = 1'b0;
    cnt = 0;
    repeat (3) begin
      step();
      if (CompareValid === 1'b1) cnt++;
    end
    check("midrun reset compare", Compare, 0);
    RstN = 1'b1;
    repeat (4) begin
      step();
      if (CompareValid === 1'b1) cnt++;
    end
    check("inflight discarded", cnt, 0);

    // Waveform from phase 0 after reset.
    do_tick("tick0 after reset", 16'd250);
    skip_ticks(63);
    do_tick("tick64", 16'd499);
    skip_ticks(127);
    do_tick("tick192", 16'd1);
    skip_ticks(63);
    do_tick("tick256 wrap", 16'd250);

    // Five consecutive ticks -> five consecutive valids, 3 edges later.
    cnt     = 0;
    first_e = -1;
    last_e  = -1;
    for (int e = 0; e < 12; e++) begin
      UpdateTick = (e < 5);
      step();
      if (CompareValid === 1'b1) begin
        cnt++;
        if (first_e < 0) first_e = e;
        last_e = e;
      end
    end
    UpdateTick = 1'b0;
    check("burst valid count", cnt, 5);
    check("burst first valid edge", first_e, 3);
    check("burst last valid edge", last_e, 7);

    // Half amplitude at the positive peak.
    restart();
    Amplitude = 16'h8000;
    skip_ticks(64);
    do_tick("half amp tick64", 16'd374);

    // Zero amplitude sits at mid-scale.
    restart();
    Amplitude = 16'h0000;
    do_tick("zero amp tick0", 16'd250);
    do_tick("zero amp tick1", 16'd250);
    skip_ticks(62);
    do_tick("zero amp tick64", 16'd250);

    // Re-enable restarts at phase 0 (tick 64 would otherwise give 499).
    Amplitude = 16'hFFFF;
    restart();
    skip_ticks(64);
    restart();
    do_tick("reenable phase0", 16'd250);

    // Enable dropped with ticks still arriving: only the two accepted
    // ticks emit; Compare holds the tick-1 value (phase 0x0100_0000 -> 256).
    restart();
    cnt = 0;
    for (int e = 0; e < 12; e++) begin
      UpdateTick = (e < 6);
      if (e == 2) Enable = 1'b0;
      step();
      if (CompareValid === 1'b1) cnt++;
    end
    UpdateTick = 1'b0;
    check("enable drop valid count", cnt, 2);
    check("enable drop hold compare", Compare, 256);
    Enable = 1'b1;
    do_tick("after drop phase0", 16'd250);

    // Zero carrier span forces Compare to 0.
    restart();
    PWMMaxCount = 16'd0;
    do_tick("max0 tick0", 16'd0);
    skip_ticks(63);
    do_tick("max0 tick64", 16'd0);
    PWMMaxCount = 16'd500;

`ifdef PHASE_OFFSET_EN
    restart();
    PhaseOffset = 32'h4000_0000;
    do_tick("offset 90deg tick0", 16'd499);
    PhaseOffset = 32'h0;
`endif

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
